// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline hazard detector: load-use bubble, memory-wait freeze, branch flush, stall counter
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_read_reg1,
  input  logic [4:0]  IF_ID_read_reg2,
  input  logic        IF_ID_uses_rs1,
  input  logic        IF_ID_uses_rs2,
  input  logic        IF_ID_is_branch,
  input  logic        branch_taken,
  input  logic [4:0]  ID_EXE_written_reg,
  input  logic [1:0]  ID_EXE_DatatoReg,
  input  logic        EXE_MEM_mem_access,
  input  logic        mem_ready,
  input  logic        count_clear,
  output logic        PC_write_en,
  output logic        IF_ID_write_en,
  output logic        ID_EXE_bubble,
  output logic        IF_ID_flush,
  output logic        pipe_freeze,
  output logic [1:0]  stall_state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  state_t state;
  state_t next_state;

  logic load_use;
  logic mem_stall;
  logic pc_en;
  logic ifid_en;
  logic bubble;
  logic freeze;

  assign load_use = (ID_EXE_DatatoReg == 2'b01) && (ID_EXE_written_reg != 5'd0) &&
                    ((IF_ID_uses_rs1 && (IF_ID_read_reg1 == ID_EXE_written_reg)) ||
                     (IF_ID_uses_rs2 && (IF_ID_read_reg2 == ID_EXE_written_reg)));
  assign mem_stall = EXE_MEM_mem_access && !mem_ready;

  // MEM_WAIT release evaluates like RUN, so a load-use deferred by a freeze still gets its bubble
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    bubble     = 1'b0;
    freeze     = 1'b0;
    next_state = RUN;
    case (state)
      RUN, LOAD_STALL, MEM_WAIT: begin
        if (mem_stall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          freeze     = 1'b1;
          next_state = MEM_WAIT;
        end else if (load_use && (state != LOAD_STALL)) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          bubble     = 1'b1;
          next_state = LOAD_STALL;
        end
      end
      default: next_state = RUN;
    endcase
  end

  assign PC_write_en    = !rst && pc_en;
  assign IF_ID_write_en = !rst && ifid_en;
  assign ID_EXE_bubble  = !rst && bubble;
  assign pipe_freeze    = !rst && freeze;
  assign IF_ID_flush    = !rst && IF_ID_is_branch && branch_taken && pc_en && !freeze;
  assign stall_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      stall_count <= 16'd0;
    end else begin
      state <= next_state;
      if (count_clear)
        stall_count <= 16'd0;
      else if (!pc_en && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit against a rule-level reference model
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  IF_ID_read_reg1 = 5'd0;
  logic [4:0]  IF_ID_read_reg2 = 5'd0;
  logic        IF_ID_uses_rs1 = 1'b0;
  logic        IF_ID_uses_rs2 = 1'b0;
  logic        IF_ID_is_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [4:0]  ID_EXE_written_reg = 5'd0;
  logic [1:0]  ID_EXE_DatatoReg = 2'b00;
  logic        EXE_MEM_mem_access = 1'b0;
  logic        mem_ready = 1'b1;
  logic        count_clear = 1'b0;
  logic        PC_write_en;
  logic        IF_ID_write_en;
  logic        ID_EXE_bubble;
  logic        IF_ID_flush;
  logic        pipe_freeze;
  logic [1:0]  stall_state;
  logic [15:0] stall_count;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .IF_ID_read_reg1(IF_ID_read_reg1), .IF_ID_read_reg2(IF_ID_read_reg2),
    .IF_ID_uses_rs1(IF_ID_uses_rs1), .IF_ID_uses_rs2(IF_ID_uses_rs2),
    .IF_ID_is_branch(IF_ID_is_branch), .branch_taken(branch_taken),
    .ID_EXE_written_reg(ID_EXE_written_reg), .ID_EXE_DatatoReg(ID_EXE_DatatoReg),
    .EXE_MEM_mem_access(EXE_MEM_mem_access), .mem_ready(mem_ready),
    .count_clear(count_clear),
    .PC_write_en(PC_write_en), .IF_ID_write_en(IF_ID_write_en),
    .ID_EXE_bubble(ID_EXE_bubble), .IF_ID_flush(IF_ID_flush),
    .pipe_freeze(pipe_freeze), .stall_state(stall_state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc, ifid, bub, flush, frz, st, cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Reference model: the only memory a hazard unit needs is "a bubble was just
  // issued" (so the same load-use is not charged twice) plus the stall counter.
  int   m_state = 0;
  int   m_cnt = 0;

  task automatic chk(input string nm, input int act, input int ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, ex, $time);
    end
  endtask

  task automatic step(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                      input bit br, input bit tk, input int wr, input int dr,
                      input bit ma, input bit mr, input bit cc);
    exp_t e;
    bit lu, ms;
    @(negedge clk);
    rst = r;
    IF_ID_read_reg1 = 5'(rs1); IF_ID_read_reg2 = 5'(rs2);
    IF_ID_uses_rs1 = u1; IF_ID_uses_rs2 = u2;
    IF_ID_is_branch = br; branch_taken = tk;
    ID_EXE_written_reg = 5'(wr); ID_EXE_DatatoReg = 2'(dr);
    EXE_MEM_mem_access = ma; mem_ready = mr; count_clear = cc;
    lu = (dr == 1) && (wr != 0) && ((u1 && rs1 == wr) || (u2 && rs2 == wr));
    ms = ma && !mr;
    if (r) begin
      e = '{0, 0, 0, 0, 0, 0, 0};
      m_state = 0;
      m_cnt = 0;
    end else begin
      e.frz = ms ? 1 : 0;
      e.bub = (!ms && lu && m_state != 1) ? 1 : 0;
      e.pc = (e.frz || e.bub) ? 0 : 1;
      e.ifid = e.pc;
      e.flush = (br && tk && e.pc == 1) ? 1 : 0;
      e.st = m_state;
      e.cnt = m_cnt;
      if (cc) m_cnt = 0;
      else if (e.pc == 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_state = e.frz ? 2 : (e.bub ? 1 : 0);
    end
    q.push_back(e);
  endtask

  task automatic idle(input bit ma, input bit mr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ma, mr, 0);
  endtask

  // Monitor samples combinational outputs mid-low-phase, after the driver settles inputs.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC_write_en", int'(PC_write_en), e.pc);
        chk("IF_ID_write_en", int'(IF_ID_write_en), e.ifid);
        chk("ID_EXE_bubble", int'(ID_EXE_bubble), e.bub);
        chk("IF_ID_flush", int'(IF_ID_flush), e.flush);
        chk("pipe_freeze", int'(pipe_freeze), e.frz);
        chk("stall_state", int'(stall_state), e.st);
        chk("stall_count", int'(stall_count), e.cnt);
      end
    end
  end

  initial begin
    int wait_cycles;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 1);
    // load-use on rs1: one bubble, one LOAD_STALL cycle, back to RUN
    step(0, 5, 0, 1, 0, 0, 0, 5, 1, 0, 1, 0);
    step(0, 5, 0, 1, 0, 0, 0, 5, 1, 0, 1, 0);
    idle(0, 1);
    // x0 destination and unused rs2 never stall
    step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 7, 1, 0, 0, 0, 7, 1, 0, 1, 0);
    step(0, 7, 0, 0, 1, 0, 0, 7, 1, 0, 1, 0);
    // memory wait of three cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) idle(1, 0);
    idle(1, 1);
    idle(0, 1);
    // simultaneous load-use and mem stall: freeze first, bubble after release
    step(0, 3, 0, 1, 0, 0, 0, 3, 1, 1, 0, 0);
    step(0, 3, 0, 1, 0, 0, 0, 3, 1, 1, 1, 0);
    step(0, 3, 0, 1, 0, 0, 0, 3, 1, 0, 1, 0);
    idle(0, 1);
    // taken branch flushes; with a load-use hazard the flush waits a cycle
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    step(0, 9, 0, 1, 0, 1, 1, 9, 1, 0, 1, 0);
    step(0, 9, 0, 1, 0, 1, 1, 9, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // count_clear during a stall wins over increment
    idle(1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1, 0);
    // reset asserted mid-MEM_WAIT, then resume cleanly
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    step(0, 4, 0, 1, 0, 0, 0, 4, 1, 0, 1, 0);
    idle(0, 1);
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) == 0),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 99) == 0));
    end
    // long freeze drives the counter into saturation
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    repeat (65540) idle(1, 0);
    idle(0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(0, 1);
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
